// File: rtl/tdma_pkg.sv
// Shared types for the tensor-DMA N-D burst iterator: descriptor, burst and FSM state.
package tdma_pkg;

  localparam int TDMA_ADDR_WIDTH = 64;
  localparam int TDMA_NUM_DIM    = 4;

  typedef struct packed {
    logic [TDMA_ADDR_WIDTH-1:0]     src_addr;
    logic [TDMA_ADDR_WIDTH-1:0]     dst_addr;
    logic [TDMA_NUM_DIM-1:0][31:0]  src_stride;
    logic [TDMA_NUM_DIM-1:0][31:0]  dst_stride;
    logic [TDMA_NUM_DIM:0][31:0]    shape;
  } tdma_desc_t;

  typedef struct packed {
    logic [TDMA_ADDR_WIDTH-1:0] src;
    logic [TDMA_ADDR_WIDTH-1:0] dst;
    logic [31:0]                len;
  } tdma_burst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } tdma_state_e;

endpackage

// File: rtl/tdma_odometer.sv
// Dimension counters and per-dimension base registers for both address paths;
// advances by one burst per step_i and flags when the current burst is the last.
module tdma_odometer
  import tdma_pkg::*;
#(
  parameter int ADDR_WIDTH = TDMA_ADDR_WIDTH,
  parameter int NUM_DIM    = TDMA_NUM_DIM
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] src_base_i,
  input  logic [ADDR_WIDTH-1:0] dst_base_i,
  input  logic [NUM_DIM*32-1:0] src_stride_i,
  input  logic [NUM_DIM*32-1:0] dst_stride_i,
  input  logic [NUM_DIM*32-1:0] extent_i,
  output logic [ADDR_WIDTH-1:0] src_addr_o,
  output logic [ADDR_WIDTH-1:0] dst_addr_o,
  output logic                  last_o
);

  logic [31:0]           cnt_q   [NUM_DIM];
  logic [31:0]           cnt_d   [NUM_DIM];
  logic [31:0]           ext_q   [NUM_DIM];
  logic [31:0]           sstr_q  [NUM_DIM];
  logic [31:0]           dstr_q  [NUM_DIM];
  logic [ADDR_WIDTH-1:0] sbase_q [NUM_DIM];
  logic [ADDR_WIDTH-1:0] sbase_d [NUM_DIM];
  logic [ADDR_WIDTH-1:0] dbase_q [NUM_DIM];
  logic [ADDR_WIDTH-1:0] dbase_d [NUM_DIM];
  logic [ADDR_WIDTH-1:0] scur_q, scur_d;
  logic [ADDR_WIDTH-1:0] dcur_q, dcur_d;
  logic [ADDR_WIDTH-1:0] s_new, d_new;
  logic [NUM_DIM-1:0]    at_max;
  int                    sel;

  always_comb begin
    for (int i = 0; i < NUM_DIM; i++) begin
      at_max[i] = (cnt_q[i] == ext_q[i] - 32'd1);
    end
  end

  assign last_o     = &at_max;
  assign src_addr_o = scur_q;
  assign dst_addr_o = dcur_q;

  // sel is the lowest dimension that can still count; NUM_DIM means none can.
  always_comb begin
    cnt_d   = cnt_q;
    sbase_d = sbase_q;
    dbase_d = dbase_q;
    scur_d  = scur_q;
    dcur_d  = dcur_q;
    s_new   = '0;
    d_new   = '0;
    sel     = NUM_DIM;
    for (int i = NUM_DIM - 1; i >= 0; i--) begin
      if (!at_max[i]) sel = i;
    end
    for (int i = 0; i < NUM_DIM; i++) begin
      if (i == sel) begin
        s_new = sbase_q[i] + ADDR_WIDTH'(sstr_q[i]);
        d_new = dbase_q[i] + ADDR_WIDTH'(dstr_q[i]);
      end
    end
    if (load_i) begin
      for (int i = 0; i < NUM_DIM; i++) begin
        cnt_d[i]   = '0;
        sbase_d[i] = src_base_i;
        dbase_d[i] = dst_base_i;
      end
      scur_d = src_base_i;
      dcur_d = dst_base_i;
    end else if (step_i && (sel < NUM_DIM)) begin
      for (int i = 0; i < NUM_DIM; i++) begin
        if (i <= sel) begin
          cnt_d[i]   = (i == sel) ? cnt_q[i] + 32'd1 : 32'd0;
          sbase_d[i] = s_new;
          dbase_d[i] = d_new;
        end
      end
      scur_d = s_new;
      dcur_d = d_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_DIM; i++) begin
        cnt_q[i]   <= '0;
        ext_q[i]   <= '0;
        sstr_q[i]  <= '0;
        dstr_q[i]  <= '0;
        sbase_q[i] <= '0;
        dbase_q[i] <= '0;
      end
      scur_q <= '0;
      dcur_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sbase_q <= sbase_d;
      dbase_q <= dbase_d;
      scur_q  <= scur_d;
      dcur_q  <= dcur_d;
      if (load_i) begin
        for (int i = 0; i < NUM_DIM; i++) begin
          ext_q[i]  <= extent_i[i*32 +: 32];
          sstr_q[i] <= src_stride_i[i*32 +: 32];
          dstr_q[i] <= dst_stride_i[i*32 +: 32];
        end
      end
    end
  end

endmodule

// File: rtl/tdma_nd_iter.sv
// N-D burst iterator: unrolls one tensor descriptor into 1-D bursts and pulses
// done_o after the last completion. Optional perf counters: TDMA_ND_ITER_PERF_EN.
module tdma_nd_iter
  import tdma_pkg::*;
#(
  parameter int ADDR_WIDTH      = TDMA_ADDR_WIDTH,
  parameter int NUM_DIM         = TDMA_NUM_DIM,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       desc_valid_i,
  output logic                       desc_ready_o,
  input  logic [ADDR_WIDTH-1:0]      src_addr_i,
  input  logic [ADDR_WIDTH-1:0]      dst_addr_i,
  input  logic [NUM_DIM*32-1:0]      src_stride_i,
  input  logic [NUM_DIM*32-1:0]      dst_stride_i,
  input  logic [(NUM_DIM+1)*32-1:0]  shape_i,
  output logic                       burst_valid_o,
  input  logic                       burst_ready_i,
  output logic [ADDR_WIDTH-1:0]      burst_src_o,
  output logic [ADDR_WIDTH-1:0]      burst_dst_o,
  output logic [31:0]                burst_len_o,
  input  logic                       burst_done_i,
  output logic                       busy_o,
  output logic                       done_o,
`ifdef TDMA_ND_ITER_PERF_EN
  output logic [31:0]                perf_bursts_o,
  output logic [31:0]                perf_stall_o,
`endif
  output logic [1:0]                 dbg_state_o
);

  localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]  OUT_MAX = CW'(MAX_OUTSTANDING);

  tdma_state_e   state_q, state_d;
  logic [CW-1:0] out_q, out_d;
  logic [31:0]   len_q;
  logic          drain_seen_q;
  logic          desc_hs, burst_hs, done_eff, zero_shape, last;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; once burst_valid_o rises it and the burst fields hold until ready.
  assign desc_hs  = desc_valid_i & desc_ready_o;
  assign burst_hs = burst_valid_o & burst_ready_i;
  assign done_eff = burst_done_i & (out_q != '0);

  always_comb begin
    zero_shape = 1'b0;
    for (int d = 0; d <= NUM_DIM; d++) begin
      if (shape_i[d*32 +: 32] == 32'd0) zero_shape = 1'b1;
    end
  end

  always_comb begin
    out_d = out_q;
    case ({burst_hs, done_eff})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  // drain_seen_q keeps done_o off in the first DRAIN cycle, so a descriptor
  // with nothing to issue still takes one settle cycle before completing.
  always_comb begin
    state_d       = state_q;
    desc_ready_o  = 1'b0;
    burst_valid_o = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        desc_ready_o = 1'b1;
        if (desc_valid_i) state_d = zero_shape ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        burst_valid_o = (out_q != OUT_MAX);
        if (burst_valid_o && burst_ready_i && last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_seen_q && (out_q == '0)) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      len_q        <= '0;
      drain_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      drain_seen_q <= (state_q == ST_DRAIN);
      if (desc_hs) len_q <= shape_i[31:0];
    end
  end

  tdma_odometer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_DIM    (NUM_DIM)
  ) u_odometer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (desc_hs),
    .step_i       (burst_hs),
    .src_base_i   (src_addr_i),
    .dst_base_i   (dst_addr_i),
    .src_stride_i (src_stride_i),
    .dst_stride_i (dst_stride_i),
    .extent_i     (shape_i[(NUM_DIM+1)*32-1:32]),
    .src_addr_o   (burst_src_o),
    .dst_addr_o   (burst_dst_o),
    .last_o       (last)
  );

  assign burst_len_o = len_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

`ifdef TDMA_ND_ITER_PERF_EN
  logic [31:0] perf_bursts_q, perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_bursts_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (burst_hs && (perf_bursts_q != '1)) perf_bursts_q <= perf_bursts_q + 32'd1;
      if (burst_valid_o && !burst_ready_i && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_bursts_o = perf_bursts_q;
  assign perf_stall_o  = perf_stall_q;
`endif

  // A completion with nothing outstanding is a backend protocol error.
  a_no_spurious_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(burst_done_i && (out_q == '0)));

endmodule

// File: tb/tb_tdma_nd_iter.sv
// Bench for tdma_nd_iter: directed tensors plus random descriptors checked
// against a nested-loop address model and a cycle-level handshake model.
module tb_tdma_nd_iter;

  localparam int AW      = 64;
  localparam int ND      = 4;
  localparam int MAX_OUT = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            desc_valid_i = 1'b0;
  logic            desc_ready_o;
  logic [AW-1:0]   src_addr_i = '0;
  logic [AW-1:0]   dst_addr_i = '0;
  logic [127:0]    src_stride_i = '0;
  logic [127:0]    dst_stride_i = '0;
  logic [159:0]    shape_i = '0;
  logic            burst_valid_o;
  logic            burst_ready_i = 1'b0;
  logic [AW-1:0]   burst_src_o;
  logic [AW-1:0]   burst_dst_o;
  logic [31:0]     burst_len_o;
  logic            burst_done_i = 1'b0;
  logic            busy_o;
  logic            done_o;
  logic [1:0]      dbg_state_o;
`ifdef TDMA_ND_ITER_PERF_EN
  logic [31:0]     perf_bursts_o;
  logic [31:0]     perf_stall_o;
`endif

  // ---------------- clock / reset
  always #5 clk_i = ~clk_i;

  tdma_nd_iter #(
    .ADDR_WIDTH      (AW),
    .NUM_DIM         (ND),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .desc_valid_i  (desc_valid_i),
    .desc_ready_o  (desc_ready_o),
    .src_addr_i    (src_addr_i),
    .dst_addr_i    (dst_addr_i),
    .src_stride_i  (src_stride_i),
    .dst_stride_i  (dst_stride_i),
    .shape_i       (shape_i),
    .burst_valid_o (burst_valid_o),
    .burst_ready_i (burst_ready_i),
    .burst_src_o   (burst_src_o),
    .burst_dst_o   (burst_dst_o),
    .burst_len_o   (burst_len_o),
    .burst_done_i  (burst_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
`ifdef TDMA_ND_ITER_PERF_EN
    .perf_bursts_o (perf_bursts_o),
    .perf_stall_o  (perf_stall_o),
`endif
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- scoreboard state
  int           vectors = 0;
  int           miscompares = 0;
  logic [159:0] exp_q[$];
  int           pending = 0;
  int           done_cd = 0;
  int           obs_hs = 0;
  bit           busy_m = 0;
  bit           desc_pend = 0;
  bit           zero_m = 0;
  int           ready_pct = 100;
  int           done_pct = 100;
  int           ready_low = 0;
  int           done_once = 0;
  logic [31:0]  perf_b_m = '0;
  logic [31:0]  perf_s_m = '0;
  logic [63:0]  d_src, d_dst;
  logic [31:0]  d_sstr[4];
  logic [31:0]  d_dstr[4];
  logic [31:0]  d_shape[5];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected bursts: dim 1 fastest, address = base + sum(i_d * stride_d) mod 2^64.
  task automatic build_expected();
    logic [63:0] s, d;
    zero_m = 0;
    for (int k = 0; k < 5; k++) if (d_shape[k] == 0) zero_m = 1;
    if (!zero_m) begin
      for (int i4 = 0; i4 < int'(d_shape[4]); i4++)
        for (int i3 = 0; i3 < int'(d_shape[3]); i3++)
          for (int i2 = 0; i2 < int'(d_shape[2]); i2++)
            for (int i1 = 0; i1 < int'(d_shape[1]); i1++) begin
              s = d_src + 64'(i1) * 64'(d_sstr[0]) + 64'(i2) * 64'(d_sstr[1])
                        + 64'(i3) * 64'(d_sstr[2]) + 64'(i4) * 64'(d_sstr[3]);
              d = d_dst + 64'(i1) * 64'(d_dstr[0]) + 64'(i2) * 64'(d_dstr[1])
                        + 64'(i3) * 64'(d_dstr[2]) + 64'(i4) * 64'(d_dstr[3]);
              exp_q.push_back({s, d, d_shape[0]});
            end
    end
  endtask

  // ---------------- driver tasks
  task automatic set_desc(input logic [63:0] s, input logic [63:0] d,
                          input logic [127:0] ss, input logic [127:0] ds,
                          input logic [159:0] sh);
    d_src = s;
    d_dst = d;
    for (int k = 0; k < 4; k++) begin
      d_sstr[k] = ss[k*32 +: 32];
      d_dstr[k] = ds[k*32 +: 32];
    end
    for (int k = 0; k < 5; k++) d_shape[k] = sh[k*32 +: 32];
    src_addr_i   = s;
    dst_addr_i   = d;
    src_stride_i = ss;
    dst_stride_i = ds;
    shape_i      = sh;
    desc_pend    = 1;
  endtask

  // One clock: drive after the rising edge, check and update the model at the falling edge.
  task automatic step();
    bit exp_valid, exp_done, d_hs;
    @(posedge clk_i);
    #1;
    desc_valid_i = desc_pend;
    if (ready_low > 0) begin
      burst_ready_i = 1'b0;
      ready_low--;
    end else begin
      burst_ready_i = ($urandom_range(99) < ready_pct);
    end
    burst_done_i = 1'b0;
    if (pending > 0 && (done_once > 0 || $urandom_range(99) < done_pct)) begin
      burst_done_i = 1'b1;
      if (done_once > 0) done_once--;
    end
    @(negedge clk_i);
    exp_valid = busy_m && (exp_q.size() > 0) && (pending < MAX_OUT);
    exp_done  = (done_cd == 1);
    if (done_cd > 0) done_cd--;
    check("desc_ready", desc_ready_o, !busy_m);
    check("busy", busy_o, busy_m);
    check("burst_valid", burst_valid_o, exp_valid);
    check("done", done_o, exp_done);
    if (exp_valid) check("burst_fields", {burst_src_o, burst_dst_o, burst_len_o}, exp_q[0]);
`ifdef TDMA_ND_ITER_PERF_EN
    check("perf_bursts", perf_bursts_o, perf_b_m);
    check("perf_stall", perf_stall_o, perf_s_m);
`endif
    if (burst_valid_o && burst_ready_i) obs_hs++;
    d_hs = desc_valid_i && !busy_m;
    if (exp_valid && !burst_ready_i && perf_s_m != '1) perf_s_m++;
    if (exp_valid && burst_ready_i) begin
      void'(exp_q.pop_front());
      pending++;
      if (perf_b_m != '1) perf_b_m++;
    end
    if (burst_done_i) pending--;
    if (exp_done) busy_m = 0;
    if (d_hs) begin
      busy_m    = 1;
      desc_pend = 0;
      build_expected();
    end
    if (busy_m && done_cd == 0 && exp_q.size() == 0 && pending == 0)
      done_cd = d_hs ? 2 : 1;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((busy_m || desc_pend) && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_timeout", (busy_m || desc_pend), 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk_i);
    #1;
    rst_ni        = 1'b0;
    desc_valid_i  = 1'b0;
    burst_ready_i = 1'b0;
    burst_done_i  = 1'b0;
    exp_q.delete();
    pending   = 0;
    busy_m    = 0;
    desc_pend = 0;
    done_cd   = 0;
    perf_b_m  = '0;
    perf_s_m  = '0;
    #2;
    check("rst_desc_ready", desc_ready_o, 1'b1);
    check("rst_burst_valid", burst_valid_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_fields", {burst_src_o, burst_dst_o, burst_len_o}, 160'd0);
    check("rst_state", dbg_state_o, 2'd0);
`ifdef TDMA_ND_ITER_PERF_EN
    check("rst_perf", {perf_bursts_o, perf_stall_o}, 64'd0);
`endif
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic rand_desc();
    logic [63:0]  s, d;
    logic [127:0] ss, ds;
    logic [159:0] sh;
    int           z;
    s = {$urandom(), $urandom()};
    d = {$urandom(), $urandom()};
    if ($urandom_range(3) == 0) s = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(255));
    for (int k = 0; k < 4; k++) begin
      ss[k*32 +: 32] = ($urandom_range(1) == 1) ? $urandom() : 32'($urandom_range(4096));
      ds[k*32 +: 32] = ($urandom_range(1) == 1) ? $urandom() : 32'($urandom_range(4096));
    end
    sh[31:0] = 32'($urandom_range(256, 1));
    for (int k = 1; k < 5; k++) sh[k*32 +: 32] = 32'($urandom_range(3, 1));
    if ($urandom_range(9) == 0) begin
      z = $urandom_range(4);
      sh[z*32 +: 32] = '0;
    end
    set_desc(s, d, ss, ds, sh);
  endtask

  // ---------------- test sequence
  initial begin
    int stall_before;
    apply_reset();

    // Single-dimension run of three bursts.
    ready_pct = 100;
    done_pct  = 100;
    set_desc(64'h1000, 64'h8000, {32'd0, 32'd0, 32'd0, 32'h100}, {32'd0, 32'd0, 32'd0, 32'h40},
             {32'd1, 32'd1, 32'd1, 32'd3, 32'd64});
    run_until_idle(200);

    // Two dimensions with different src/dst strides, random backpressure.
    ready_pct = 70;
    done_pct  = 60;
    set_desc(64'h0, 64'h0, {32'd0, 32'd0, 32'h100, 32'h10}, {32'd0, 32'd0, 32'h400, 32'h20},
             {32'd1, 32'd1, 32'd2, 32'd2, 32'd8});
    run_until_idle(300);

    // Zero extent in dim 2: nothing issued, done two cycles after acceptance.
    set_desc(64'h2000, 64'h3000, 128'h1, 128'h1, {32'd1, 32'd1, 32'd0, 32'd2, 32'd16});
    run_until_idle(50);

    // Outstanding limit with completions withheld, then one released.
    ready_pct = 100;
    done_pct  = 0;
    obs_hs    = 0;
    set_desc(64'h4000, 64'h5000, {32'd0, 32'd0, 32'd0, 32'h10}, {32'd0, 32'd0, 32'd0, 32'h10},
             {32'd1, 32'd1, 32'd1, 32'd6, 32'd16});
    repeat (8) step();
    check("outstanding_cap", obs_hs, 2);
    done_once = 1;
    repeat (6) step();
    check("one_release", obs_hs, 3);
    done_pct = 50;
    run_until_idle(300);

    // Ready held low for five cycles mid-tensor.
    ready_pct = 100;
    done_pct  = 100;
    set_desc(64'h6000, 64'h7000, {32'd0, 32'd0, 32'h200, 32'h20}, {32'd0, 32'd0, 32'h400, 32'h40},
             {32'd1, 32'd1, 32'd2, 32'd4, 32'd32});
    repeat (2) step();
`ifdef TDMA_ND_ITER_PERF_EN
    stall_before = int'(perf_stall_o);
`else
    stall_before = 0;
`endif
    obs_hs    = 0;
    ready_low = 5;
    repeat (6) step();
    check("stall_no_issue", obs_hs, 1);
`ifdef TDMA_ND_ITER_PERF_EN
    check("stall_count", int'(perf_stall_o) - stall_before, 5);
`endif
    run_until_idle(300);

    // Reset with bursts outstanding, then a clean descriptor.
    done_pct = 0;
    set_desc(64'h9000, 64'hA000, {32'd0, 32'd0, 32'd0, 32'h10}, {32'd0, 32'd0, 32'd0, 32'h10},
             {32'd1, 32'd1, 32'd1, 32'd8, 32'd16});
    repeat (6) step();
    apply_reset();
    done_pct = 100;
    repeat (3) step();
    set_desc(64'hB000, 64'hC000, {32'd0, 32'd0, 32'h100, 32'h10}, {32'd0, 32'd0, 32'h100, 32'h10},
             {32'd1, 32'd1, 32'd2, 32'd2, 32'd4});
    run_until_idle(200);

    // Random descriptors under random backpressure and completion timing.
    for (int n = 0; n < 25; n++) begin
      ready_pct = $urandom_range(100, 40);
      done_pct  = $urandom_range(100, 30);
      rand_desc();
      run_until_idle(2000);
      repeat ($urandom_range(3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
